wb_scheduler: RTL
=================

# wb_scheduler

Writeback scheduler and register scoreboard for the integer register file's single write port. Arbitrates the write port between the in-order ALU writeback (fixed priority) and two long-latency units, the load/store unit (LSU) and the multiply/divide unit (MDU), which are served round-robin with valid/ready handshakes. Tracks destinations owned by in-flight long-latency operations and stalls issue on RAW/WAW hazards. Sits between the execute/writeback stages and the register file write port.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a long-latency requester may wait before the ALU path is held (range 1–255).
- i_CLK  in  1  clock, all state on rising edge
- i_RSTn  in  1  asynchronous, active-low reset
- i_ISSUE_VALID  in  1  an instruction is attempting issue this cycle
- i_ISSUE_LONG  in  1  issuing instruction's result comes from LSU/MDU
- i_ISSUE_RD_PTR / i_ISSUE_RS1_PTR / i_ISSUE_RS2_PTR  in  5 each  issuing instruction's register pointers
- o_ISSUE_STALL  out  1  issue blocked this cycle (combinational)
- i_ALU_VALID, i_ALU_RD_PTR[4:0], i_ALU_RD[31:0]  in  ALU writeback request; never back-pressured
- i_LSU_VALID, i_LSU_RD_PTR[4:0], i_LSU_RD[31:0]  in  LSU writeback request
- o_LSU_READY  out  1  LSU request consumed this cycle
- i_MDU_VALID, i_MDU_RD_PTR[4:0], i_MDU_RD[31:0]  in  MDU writeback request
- o_MDU_READY  out  1  MDU request consumed this cycle
- o_ALU_HOLD  out  1  registered; pipeline must present no ALU writeback while high
- o_WE, o_RD_PTR[4:0], o_RD[31:0]  out  register file write port

## Operation
- Grant (combinational, per cycle): ALU if i_ALU_VALID; else one of LSU/MDU. Both long valid -> round-robin pointer selects; one valid -> that one. At most one grant per cycle.
- Handshake: transfer when VALID & READY. Requesters hold VALID, RD_PTR, RD stable until READY. READY is never asserted without VALID.
- Write port: o_WE = grant & (granted RD_PTR != 0); o_RD_PTR/o_RD = granted source; zero when no grant. Writes to x0 still complete the handshake.
- Round-robin pointer: after a long grant, points at the other long unit; unchanged otherwise. Reset: points at LSU.
- Scoreboard: 32-bit pending vector, bit 0 hardwired 0.
  - Set pending[rd] on accepted issue (VALID & !STALL & LONG & rd != 0).
  - Clear pending[ptr] on completed LSU/MDU handshake.
  - Same register set and cleared in the same cycle: set wins.
- Stall: o_ISSUE_STALL = i_ISSUE_VALID & (eff[rs1] | eff[rs2] | eff[rd]), where eff = pending & ~(bit cleared this cycle). Same-cycle clear does not stall because the register file forwards the written value to reads.
- Starvation counter (8 bit):
  - Increments, saturating at STARVE_LIMIT, while a long VALID is high without a long grant.
  - Resets to 0 on any long grant or when no long VALID is pending.
  - o_ALU_HOLD registered = (counter == STARVE_LIMIT).
  - If i_ALU_VALID is asserted while hold is high (protocol violation), ALU still wins; counter stays saturated.
- Reset (asynchronous, active-low): pending = 0, counter = 0, o_ALU_HOLD = 0, pointer = LSU. Combinational outputs follow inputs. In-flight handshakes are abandoned; requesters are reset by the same reset.

## Timing
- Write-port grant and READY: same cycle as VALID (0 latency); register file write lands at the next rising edge.
- Scoreboard update is visible to stall logic on the cycle after the set/clear edge.
- Hold: asserted 1 cycle after counter reaches STARVE_LIMIT. ALU valid is low on that cycle, so the long grant occurs the same cycle. Hold deasserts the following cycle.
- Worst-case long-request wait with a continuous ALU stream: STARVE_LIMIT + 1 cycles.

## Test plan
- LSU valid rd=5 data 0xDEADBEEF, no ALU -> same-cycle o_LSU_READY=1, o_WE=1, o_RD_PTR=5, o_RD=0xDEADBEEF.
- LSU and MDU both valid continuously, no ALU -> grants alternate LSU, MDU, LSU, ...; exactly one READY per cycle.
- Long issue rd=7 accepted; then issue with rs1=7 -> stalled. MDU writeback rd=7 in cycle N -> issue reading x7 in cycle N not stalled; pending[7]=0 at N+1.
- Issue long rd=0 -> no pending bit set; subsequent reads of x0 never stall. LSU writeback rd=0 -> READY=1, o_WE=0.
- ALU valid every cycle with LSU valid, STARVE_LIMIT=8 -> o_ALU_HOLD rises after 8 wait cycles; bench drops ALU valid; LSU granted; hold falls next cycle.
- Assert i_RSTn low mid-stream with pending bits set and counter nonzero -> immediately pending=0, o_ALU_HOLD=0, stall clears; after release, first simultaneous LSU/MDU request grants LSU.

Source files
------------

// File: rtl/wb_scheduler.sv
// Writeback scheduler and register scoreboard for the integer register file.
// Arbitrates the single write port: ALU writeback has fixed priority, and LSU/MDU
// share the port round-robin through valid/ready handshakes. A pending vector
// tracks destinations owned by in-flight long-latency operations, and issue
// stalls on RAW/WAW hazards against them. A starvation counter holds the ALU
// path so a long requester is guaranteed forward progress.
module wb_scheduler #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        i_CLK,
   input  logic        i_RSTn,

   input  logic        i_ISSUE_VALID,
   input  logic        i_ISSUE_LONG,
   input  logic [4:0]  i_ISSUE_RD_PTR,
   input  logic [4:0]  i_ISSUE_RS1_PTR,
   input  logic [4:0]  i_ISSUE_RS2_PTR,
   output logic        o_ISSUE_STALL,

   input  logic        i_ALU_VALID,
   input  logic [4:0]  i_ALU_RD_PTR,
   input  logic [31:0] i_ALU_RD,

   input  logic        i_LSU_VALID,
   input  logic [4:0]  i_LSU_RD_PTR,
   input  logic [31:0] i_LSU_RD,
   output logic        o_LSU_READY,

   input  logic        i_MDU_VALID,
   input  logic [4:0]  i_MDU_RD_PTR,
   input  logic [31:0] i_MDU_RD,
   output logic        o_MDU_READY,

   output logic        o_ALU_HOLD,

   output logic        o_WE,
   output logic [4:0]  o_RD_PTR,
   output logic [31:0] o_RD
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   // Round-robin pointer: which long unit wins when both request.
   typedef enum logic {
      RR_LSU = 1'b0,
      RR_MDU = 1'b1
   } rr_e;

   rr_e         rr_q, rr_d;
   logic [31:0] pend_q, pend_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        hold_q, hold_d;

   logic        alu_gnt, lsu_gnt, mdu_gnt;
   logic        long_gnt, long_req;
   logic [31:0] clr_vec, set_vec, eff_vec;
   logic        issue_ok;

   // Port arbitration: ALU first, otherwise one long unit (round-robin on contention).
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      mdu_gnt = 1'b0;
      if (i_ALU_VALID) begin
         alu_gnt = 1'b1;
      end else if (i_LSU_VALID && i_MDU_VALID) begin
         if (rr_q == RR_LSU) lsu_gnt = 1'b1;
         else                mdu_gnt = 1'b1;
      end else if (i_LSU_VALID) begin
         lsu_gnt = 1'b1;
      end else if (i_MDU_VALID) begin
         mdu_gnt = 1'b1;
      end
   end

   assign long_gnt    = lsu_gnt | mdu_gnt;
   assign long_req    = i_LSU_VALID | i_MDU_VALID;
   assign o_LSU_READY = lsu_gnt;
   assign o_MDU_READY = mdu_gnt;
   assign o_ALU_HOLD  = hold_q;

   // Register file write port mux; x0 writes complete the handshake but never write.
   always_comb begin
      o_WE     = 1'b0;
      o_RD_PTR = '0;
      o_RD     = '0;
      if (alu_gnt) begin
         o_WE     = (i_ALU_RD_PTR != 5'd0);
         o_RD_PTR = i_ALU_RD_PTR;
         o_RD     = i_ALU_RD;
      end else if (lsu_gnt) begin
         o_WE     = (i_LSU_RD_PTR != 5'd0);
         o_RD_PTR = i_LSU_RD_PTR;
         o_RD     = i_LSU_RD;
      end else if (mdu_gnt) begin
         o_WE     = (i_MDU_RD_PTR != 5'd0);
         o_RD_PTR = i_MDU_RD_PTR;
         o_RD     = i_MDU_RD;
      end
   end

   // Scoreboard: same-cycle clears are forwarded by the register file, so they
   // are masked out of the hazard check; a same-cycle set overrides a clear.
   always_comb begin
      clr_vec = '0;
      if (lsu_gnt) clr_vec[i_LSU_RD_PTR] = 1'b1;
      if (mdu_gnt) clr_vec[i_MDU_RD_PTR] = 1'b1;

      eff_vec = pend_q & ~clr_vec;

      o_ISSUE_STALL = i_ISSUE_VALID &
                      (eff_vec[i_ISSUE_RS1_PTR] |
                       eff_vec[i_ISSUE_RS2_PTR] |
                       eff_vec[i_ISSUE_RD_PTR]);

      issue_ok = i_ISSUE_VALID & ~o_ISSUE_STALL & i_ISSUE_LONG &
                 (i_ISSUE_RD_PTR != 5'd0);

      set_vec = '0;
      if (issue_ok) set_vec[i_ISSUE_RD_PTR] = 1'b1;

      pend_d    = (pend_q & ~clr_vec) | set_vec;
      pend_d[0] = 1'b0;
   end

   // Next round-robin pointer: after a long grant, favour the other unit.
   always_comb begin
      rr_d = rr_q;
      if (lsu_gnt)      rr_d = RR_MDU;
      else if (mdu_gnt) rr_d = RR_LSU;
   end

   // Starvation counter and next-cycle ALU hold.
   always_comb begin
      cnt_d = cnt_q;
      if (long_gnt || !long_req) begin
         cnt_d = '0;
      end else if (cnt_q < LIMIT) begin
         cnt_d = cnt_q + 8'd1;
      end
      hold_d = (cnt_d == LIMIT);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         rr_q   <= RR_LSU;
         pend_q <= '0;
         cnt_q  <= '0;
         hold_q <= 1'b0;
      end else begin
         rr_q   <= rr_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
      end
   end

endmodule
